ristretto_trap_ctrl: RTL and testbench



---
 rtl/ristretto_trap_ctrl_if.sv | 12 +
 rtl/ristretto_trap_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ristretto_trap_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ristretto_trap_ctrl_if.sv
// Redirect channel from the trap control unit (master) to fetch (slave).
// valid/ready: the master raises valid with a stable pc and holds both until a cycle where ready is also high; that edge transfers the redirect.
interface ristretto_trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;

  modport master (output redirect_valid, output redirect_pc, input redirect_ready);
  modport slave  (input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/ristretto_trap_ctrl.sv
// Execute-stage trap control: arbitrates interrupts/exceptions/MRET, owns mepc/mcause/mstatus, redirects fetch.
// Optional macro RISTRETTO_TRAP_MTVAL_EN adds the mtval register.
module ristretto_trap_ctrl #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             instr_valid_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [1:0]       instr_trap_i,
  input  logic [1:0]       lsu_trap_i,
  input  logic [1:0]       enc_trap_i,
  input  logic [XLEN-1:0]  trap_val_i,
  input  logic             msip_i,
  input  logic             mtip_i,
  input  logic             meip_i,
  input  logic [2:0]       mie_en_i,
  input  logic [XLEN-1:0]  mtvec_i,
  input  logic             csr_mstatus_we_i,
  input  logic [1:0]       csr_mstatus_i,
  input  logic             csr_mepc_we_i,
  input  logic [XLEN-1:0]  csr_mepc_i,
  output logic [1:0]       tcu_state_o,
  output logic             stall_o,
  output logic             flush_o,
  ristretto_trap_ctrl_if.master redirect_if,
  output logic [XLEN-1:0]  mepc_o,
  output logic [XLEN-1:0]  mcause_o,
  output logic [1:0]       mstatus_o,
  output logic [XLEN-1:0]  mtval_o,
  output logic             dbg_state_o
);

  localparam logic [1:0] INSTR_MISALIG_FETCH = 2'd1;
  localparam logic [1:0] INSTR_ILLEGAL_FETCH = 2'd2;
  localparam logic [1:0] LSU_MISALIG_LOAD    = 2'd1;
  localparam logic [1:0] LSU_MISALIG_STORE   = 2'd2;
  localparam logic [1:0] ENC_ECALL           = 2'd1;
  localparam logic [1:0] ENC_MRET            = 2'd2;
  localparam logic [1:0] TCU_NOTRAP          = 2'd0;
  localparam logic [1:0] TCU_INTERRUPT       = 2'd1;
  localparam logic [1:0] TCU_EXCEPTION       = 2'd2;

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t          state_q;
  logic            mie_q;
  logic            mpie_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic [2:0]      irq_pend;
  logic            irq_take;
  logic            exc_take;
  logic            mret_take;
  logic            trap_take;
  logic [4:0]      cause;
  logic [XLEN-1:0] mtvec_eff;
  logic [XLEN-1:0] trap_pc;

  // Bit 4 of cause marks an interrupt; interrupts rank MEXT > MSW > MTIM.
  always_comb begin
    irq_pend  = {meip_i, mtip_i, msip_i} & mie_en_i;
    irq_take  = mie_q && (irq_pend != 3'b000);
    exc_take  = 1'b1;
    mret_take = 1'b0;
    cause     = 5'h00;
    if (irq_take) begin
      exc_take = 1'b0;
      if (irq_pend[2])      cause = 5'h1b;
      else if (irq_pend[0]) cause = 5'h13;
      else                  cause = 5'h17;
    end else if (instr_trap_i == INSTR_MISALIG_FETCH) begin
      cause = 5'h00;
    end else if (instr_trap_i == INSTR_ILLEGAL_FETCH) begin
      cause = 5'h02;
    end else if (enc_trap_i == ENC_ECALL) begin
      cause = 5'h0b;
    end else if (lsu_trap_i == LSU_MISALIG_LOAD) begin
      cause = 5'h04;
    end else if (lsu_trap_i == LSU_MISALIG_STORE) begin
      cause = 5'h06;
    end else begin
      exc_take  = 1'b0;
      mret_take = (enc_trap_i == ENC_MRET);
    end
    trap_take = irq_take || exc_take;
  end

  assign mtvec_eff = (mtvec_i == '0) ? RESET_MTVEC : mtvec_i;
  assign trap_pc   = {mtvec_eff[XLEN-1:2], 2'b00}
                   + (((mtvec_eff[1:0] == 2'b01) && irq_take)
                      ? {{(XLEN-6){1'b0}}, cause[3:0], 2'b00} : '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      mie_q            <= 1'b0;
      mpie_q           <= 1'b0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      tcu_state_o      <= TCU_NOTRAP;
      stall_o          <= 1'b0;
      flush_o          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      flush_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid_i && (trap_take || mret_take)) begin
            state_q          <= REDIRECT;
            flush_o          <= 1'b1;
            stall_o          <= 1'b1;
            redirect_valid_q <= 1'b1;
            if (trap_take) begin
              mepc_q        <= pc_i;
              mcause_q      <= {cause[4], {(XLEN-5){1'b0}}, cause[3:0]};
              mpie_q        <= mie_q;
              mie_q         <= 1'b0;
              tcu_state_o   <= irq_take ? TCU_INTERRUPT : TCU_EXCEPTION;
              redirect_pc_q <= trap_pc;
            end else begin
              mie_q         <= mpie_q;
              mpie_q        <= 1'b1;
              redirect_pc_q <= mepc_q;
            end
          end else begin
            // Software CSR writes only land when no trap/MRET claims the cycle.
            if (csr_mstatus_we_i) {mpie_q, mie_q} <= csr_mstatus_i;
            if (csr_mepc_we_i)    mepc_q          <= csr_mepc_i;
          end
        end
        REDIRECT: begin
          if (redirect_if.redirect_ready) begin
            state_q          <= IDLE;
            stall_o          <= 1'b0;
            redirect_valid_q <= 1'b0;
            tcu_state_o      <= TCU_NOTRAP;
          end
        end
      endcase
    end
  end

`ifdef RISTRETTO_TRAP_MTVAL_EN
  logic [XLEN-1:0] mtval_q;

  // Interrupts and ECALL have no faulting value to report.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtval_q <= '0;
    end else if ((state_q == IDLE) && instr_valid_i && trap_take) begin
      mtval_q <= (exc_take && (cause != 5'h0b)) ? trap_val_i : '0;
    end
  end

  assign mtval_o = mtval_q;
`else
  logic unused_trap_val;
  assign unused_trap_val = ^trap_val_i;
  assign mtval_o         = '0;
`endif

  assign redirect_if.redirect_valid = redirect_valid_q;
  assign redirect_if.redirect_pc    = redirect_pc_q;
  assign mepc_o                     = mepc_q;
  assign mcause_o                   = mcause_q;
  assign mstatus_o                  = {mpie_q, mie_q};
  assign dbg_state_o                = state_q;

endmodule

// File: tb/tb_ristretto_trap_ctrl.sv
// Bench for ristretto_trap_ctrl: directed vector table, hand sequences, and randomized traffic against a priority-list model.
module tb_ristretto_trap_ctrl;
  localparam int XLEN = 32;
  localparam logic [1:0] TS_NONE = 2'd0;
  localparam logic [1:0] TS_INT  = 2'd1;
  localparam logic [1:0] TS_EXC  = 2'd2;
`ifdef RISTRETTO_TRAP_MTVAL_EN
  localparam bit MTVAL_ON = 1'b1;
`else
  localparam bit MTVAL_ON = 1'b0;
`endif

  logic            clk_i, rst_ni, instr_valid_i;
  logic [XLEN-1:0] pc_i, trap_val_i, mtvec_i, csr_mepc_i;
  logic [1:0]      instr_trap_i, lsu_trap_i, enc_trap_i, csr_mstatus_i;
  logic            msip_i, mtip_i, meip_i, csr_mstatus_we_i, csr_mepc_we_i;
  logic [2:0]      mie_en_i;
  logic [1:0]      tcu_state_o, mstatus_o;
  logic            stall_o, flush_o, dbg_state_o;
  logic [XLEN-1:0] mepc_o, mcause_o, mtval_o;

  ristretto_trap_ctrl_if #(.XLEN(XLEN)) rif ();

  ristretto_trap_ctrl #(.XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_valid_i(instr_valid_i), .pc_i(pc_i),
    .instr_trap_i(instr_trap_i), .lsu_trap_i(lsu_trap_i), .enc_trap_i(enc_trap_i),
    .trap_val_i(trap_val_i), .msip_i(msip_i), .mtip_i(mtip_i), .meip_i(meip_i),
    .mie_en_i(mie_en_i), .mtvec_i(mtvec_i), .csr_mstatus_we_i(csr_mstatus_we_i),
    .csr_mstatus_i(csr_mstatus_i), .csr_mepc_we_i(csr_mepc_we_i), .csr_mepc_i(csr_mepc_i),
    .tcu_state_o(tcu_state_o), .stall_o(stall_o), .flush_o(flush_o), .redirect_if(rif.master),
    .mepc_o(mepc_o), .mcause_o(mcause_o), .mstatus_o(mstatus_o), .mtval_o(mtval_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [XLEN-1:0] exp_q[$];
  logic            m_mie, m_mpie;
  logic [XLEN-1:0] m_mepc, m_mcause, m_mtval;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    instr_valid_i = 1'b0; pc_i = '0; trap_val_i = '0;
    instr_trap_i = 2'd0; lsu_trap_i = 2'd0; enc_trap_i = 2'd0;
    {meip_i, mtip_i, msip_i} = 3'b000; mie_en_i = 3'b000;
    csr_mstatus_we_i = 1'b0; csr_mstatus_i = 2'b00; csr_mepc_we_i = 1'b0; csr_mepc_i = '0;
  endtask

  task automatic junk_inputs();
    instr_valid_i = 1'b1; pc_i = $urandom; trap_val_i = $urandom; mtvec_i = $urandom;
    instr_trap_i = 2'($urandom_range(0, 3)); lsu_trap_i = 2'($urandom_range(0, 3));
    enc_trap_i = 2'($urandom_range(0, 3));
    {meip_i, mtip_i, msip_i} = 3'b111; mie_en_i = 3'b111;
    csr_mstatus_we_i = 1'b1; csr_mstatus_i = 2'($urandom_range(0, 3));
    csr_mepc_we_i = 1'b1; csr_mepc_i = $urandom;
  endtask

  task automatic drive_instr(input logic [XLEN-1:0] pc, input logic [1:0] it, input logic [1:0] lt,
                             input logic [1:0] et, input logic [2:0] ip, input logic [2:0] en,
                             input logic [XLEN-1:0] mtvec, input logic [XLEN-1:0] tval);
    instr_valid_i = 1'b1; pc_i = pc; instr_trap_i = it; lsu_trap_i = lt; enc_trap_i = et;
    {meip_i, mtip_i, msip_i} = ip; mie_en_i = en; mtvec_i = mtvec; trap_val_i = tval;
  endtask

  // Hold ready low for 'hold' cycles while garbage is offered, then accept the redirect.
  task automatic finish_redirect(input int hold, input logic [1:0] exp_state);
    for (int c = 0; c < hold; c++) begin
      junk_inputs();
      rif.redirect_ready = 1'b0;
      step();
      chk("hold_stall", stall_o, 1);
      chk("hold_flush", flush_o, 0);
      chk("hold_valid", rif.redirect_valid, 1);
      chk("hold_state", tcu_state_o, exp_state);
      chk("hold_mepc", mepc_o, m_mepc);
      chk("hold_mcause", mcause_o, m_mcause);
      chk("hold_mstatus", mstatus_o, {m_mpie, m_mie});
    end
    junk_inputs();
    rif.redirect_ready = 1'b1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL redirect_pc: got 0x%0h expected nothing queued", rif.redirect_pc);
    end else begin
      checks--;
      chk("redirect_pc", rif.redirect_pc, exp_q.pop_front());
    end
    step();
    idle_inputs();
    rif.redirect_ready = 1'b0;
    chk("hs_valid", rif.redirect_valid, 0);
    chk("hs_stall", stall_o, 0);
    chk("hs_state", tcu_state_o, TS_NONE);
    chk("hs_mepc", mepc_o, m_mepc);
    chk("hs_mstatus", mstatus_o, {m_mpie, m_mie});
  endtask

  // ---------------- reference model ----------------
  // Walk the trap sources in priority order; first hit wins. kind: 0 none, 1 trap, 2 MRET.
  function automatic void model_decide(input logic [2:0] ip, input logic [2:0] en, input logic [1:0] it,
                                       input logic [1:0] lt, input logic [1:0] et,
                                       output int kind, output logic [4:0] cause);
    bit         hit [9];
    logic [4:0] code[9];
    hit[0] = m_mie && ip[2] && en[2]; code[0] = 5'h1b;
    hit[1] = m_mie && ip[0] && en[0]; code[1] = 5'h13;
    hit[2] = m_mie && ip[1] && en[1]; code[2] = 5'h17;
    hit[3] = (it == 2'd1);            code[3] = 5'h00;
    hit[4] = (it == 2'd2);            code[4] = 5'h02;
    hit[5] = (et == 2'd1);            code[5] = 5'h0b;
    hit[6] = (lt == 2'd1);            code[6] = 5'h04;
    hit[7] = (lt == 2'd2);            code[7] = 5'h06;
    hit[8] = (et == 2'd2);            code[8] = 5'h00;
    kind  = 0;
    cause = 5'h00;
    for (int i = 0; i < 9; i++) begin
      if (hit[i] && kind == 0) begin
        kind  = (i == 8) ? 2 : 1;
        cause = code[i];
      end
    end
  endfunction

  function automatic logic [XLEN-1:0] exp_trap_pc(input logic [XLEN-1:0] mtvec, input logic [4:0] cause);
    exp_trap_pc = (mtvec / 4) * 4;
    if ((mtvec % 4 == 1) && cause[4]) exp_trap_pc = exp_trap_pc + 4 * cause[3:0];
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]      mst_pre;
    logic [XLEN-1:0] pc;
    logic [1:0]      it, lt, et;
    logic [2:0]      ip, en;
    logic [XLEN-1:0] mtvec, tval;
    logic            exp_flush;
    logic [1:0]      exp_state;
    logic [XLEN-1:0] exp_mcause, exp_mepc, exp_rpc;
    logic [1:0]      exp_mst;
    logic [XLEN-1:0] exp_mtval;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{2'b00, 32'h100, 2'd2, 2'd0, 2'd0, 3'b000, 3'b000, 32'h800, 32'hDEAD, 1'b1, TS_EXC, 32'h2,        32'h100, 32'h800, 2'b00, 32'hDEAD};
    vecs[1]  = '{2'b01, 32'h140, 2'd0, 2'd0, 2'd0, 3'b110, 3'b111, 32'h801, 32'h55,   1'b1, TS_INT, 32'h8000000B, 32'h140, 32'h82C, 2'b10, 32'h0};
    vecs[2]  = '{2'b00, 32'h200, 2'd0, 2'd1, 2'd1, 3'b000, 3'b000, 32'h800, 32'h77,   1'b1, TS_EXC, 32'hB,        32'h200, 32'h800, 2'b00, 32'h0};
    vecs[3]  = '{2'b10, 32'h300, 2'd0, 2'd0, 2'd2, 3'b000, 3'b000, 32'h800, 32'h0,    1'b1, TS_NONE, 32'hB,       32'h104, 32'h104, 2'b11, 32'h0};
    vecs[4]  = '{2'b01, 32'h400, 2'd0, 2'd0, 2'd2, 3'b001, 3'b001, 32'h801, 32'h0,    1'b1, TS_INT, 32'h80000003, 32'h400, 32'h80C, 2'b10, 32'h0};
    vecs[5]  = '{2'b00, 32'h500, 2'd0, 2'd0, 2'd0, 3'b100, 3'b111, 32'h800, 32'h0,    1'b0, TS_NONE, 32'h80000003, 32'h104, 32'h0,  2'b00, 32'h0};
    vecs[6]  = '{2'b01, 32'h504, 2'd0, 2'd0, 2'd0, 3'b010, 3'b101, 32'h800, 32'h0,    1'b0, TS_NONE, 32'h80000003, 32'h104, 32'h0,  2'b01, 32'h0};
    vecs[7]  = '{2'b00, 32'h508, 2'd3, 2'd3, 2'd3, 3'b000, 3'b000, 32'h800, 32'h0,    1'b0, TS_NONE, 32'h80000003, 32'h104, 32'h0,  2'b00, 32'h0};
    vecs[8]  = '{2'b00, 32'h600, 2'd1, 2'd2, 2'd0, 3'b000, 3'b000, 32'h805, 32'h601,  1'b1, TS_EXC, 32'h0,        32'h600, 32'h804, 2'b00, 32'h601};
    vecs[9]  = '{2'b00, 32'h700, 2'd0, 2'd2, 2'd0, 3'b000, 3'b000, 32'h900, 32'h1003, 1'b1, TS_EXC, 32'h6,        32'h700, 32'h900, 2'b00, 32'h1003};
    vecs[10] = '{2'b01, 32'h800, 2'd0, 2'd0, 2'd0, 3'b010, 3'b010, 32'hA01, 32'h0,    1'b1, TS_INT, 32'h80000007, 32'h800, 32'hA1C, 2'b10, 32'h0};
    vecs[11] = '{2'b00, 32'h900, 2'd0, 2'd0, 2'd1, 3'b000, 3'b000, 32'h0,   32'h99,   1'b1, TS_EXC, 32'hB,        32'h900, 32'h0,   2'b00, 32'h0};
    vecs[12] = '{2'b11, 32'hA00, 2'd2, 2'd0, 2'd0, 3'b011, 3'b111, 32'h801, 32'h0,    1'b1, TS_INT, 32'h80000003, 32'hA00, 32'h80C, 2'b10, 32'h0};
    vecs[13] = '{2'b10, 32'hB00, 2'd3, 2'd2, 2'd2, 3'b111, 3'b111, 32'h800, 32'h1234, 1'b1, TS_EXC, 32'h6,        32'hB00, 32'h800, 2'b00, 32'h1234};
  end

  // ---------------- main test ----------------
  initial begin
    vec_t v;
    idle_inputs();
    mtvec_i = '0;
    rif.redirect_ready = 1'b0;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;

    chk("rst_flush", flush_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_valid", rif.redirect_valid, 0);
    chk("rst_rpc", rif.redirect_pc, 0);
    chk("rst_mepc", mepc_o, 0);
    chk("rst_mcause", mcause_o, 0);
    chk("rst_mstatus", mstatus_o, 0);
    chk("rst_mtval", mtval_o, 0);
    chk("rst_state", tcu_state_o, TS_NONE);
    chk("rst_fsm", dbg_state_o, 0);
    m_mie = 1'b0; m_mpie = 1'b0; m_mepc = '0; m_mcause = '0; m_mtval = '0;

    // Table: preset mstatus and mepc=0x104, then commit one instruction.
    for (int i = 0; i < 14; i++) begin
      v = vecs[i];
      csr_mstatus_we_i = 1'b1; csr_mstatus_i = v.mst_pre;
      csr_mepc_we_i = 1'b1; csr_mepc_i = 32'h104;
      step();
      idle_inputs();
      drive_instr(v.pc, v.it, v.lt, v.et, v.ip, v.en, v.mtvec, v.tval);
      step();
      idle_inputs();
      chk("vec_flush", flush_o, v.exp_flush);
      chk("vec_valid", rif.redirect_valid, v.exp_flush);
      chk("vec_stall", stall_o, v.exp_flush);
      chk("vec_state", tcu_state_o, v.exp_state);
      chk("vec_mcause", mcause_o, v.exp_mcause);
      chk("vec_mepc", mepc_o, v.exp_mepc);
      chk("vec_mstatus", mstatus_o, v.exp_mst);
      m_mepc = v.exp_mepc; m_mcause = v.exp_mcause; {m_mpie, m_mie} = v.exp_mst;
      if (v.exp_flush && v.exp_state != TS_NONE) m_mtval = MTVAL_ON ? v.exp_mtval : '0;
      chk("vec_mtval", mtval_o, m_mtval);
      if (v.exp_flush) begin
        exp_q.push_back(v.exp_rpc);
        finish_redirect((i == 0) ? 5 : i % 3, v.exp_state);
      end
    end

    // Trap and CSR writes in the same cycle: the trap wins.
    csr_mstatus_we_i = 1'b1; csr_mstatus_i = 2'b00; step(); idle_inputs();
    drive_instr(32'hC00, 2'd2, 2'd0, 2'd0, 3'b000, 3'b000, 32'h800, 32'h0);
    csr_mstatus_we_i = 1'b1; csr_mstatus_i = 2'b11; csr_mepc_we_i = 1'b1; csr_mepc_i = 32'h5555;
    step();
    idle_inputs();
    chk("ovr_mepc", mepc_o, 32'hC00);
    chk("ovr_mstatus", mstatus_o, 2'b00);
    chk("ovr_mcause", mcause_o, 32'h2);

    // Asynchronous reset while the redirect is still pending.
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", rif.redirect_valid, 0);
    chk("arst_stall", stall_o, 0);
    chk("arst_fsm", dbg_state_o, 0);
    chk("arst_mepc", mepc_o, 0);
    chk("arst_mcause", mcause_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    m_mie = 1'b0; m_mpie = 1'b0; m_mepc = '0; m_mcause = '0; m_mtval = '0;

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      logic [XLEN-1:0] pc, mtvec, tval, wmepc, rpc;
      logic [1:0]      it, lt, et, wmst, m_state;
      logic [2:0]      ip, en;
      logic            valid, mst_we, mepc_we;
      int              kind;
      logic [4:0]      cause;
      pc = $urandom; tval = $urandom; wmepc = $urandom;
      mtvec = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) mtvec = '0;
      it = 2'($urandom_range(0, 3)); lt = 2'($urandom_range(0, 3)); et = 2'($urandom_range(0, 3));
      ip = 3'($urandom_range(0, 7)); en = 3'($urandom_range(0, 7));
      valid = ($urandom_range(0, 3) != 0);
      mst_we = ($urandom_range(0, 2) == 0); wmst = 2'($urandom_range(0, 3));
      mepc_we = ($urandom_range(0, 2) == 0);
      kind = 0; cause = '0; rpc = '0; m_state = TS_NONE;
      if (valid) model_decide(ip, en, it, lt, et, kind, cause);
      if (kind == 1) begin
        rpc = exp_trap_pc(mtvec, cause);
        m_mepc = pc;
        m_mcause = (cause[4] ? 32'h8000_0000 : 32'h0) + 32'(cause[3:0]);
        m_mpie = m_mie; m_mie = 1'b0;
        m_state = cause[4] ? TS_INT : TS_EXC;
        m_mtval = (MTVAL_ON && !cause[4] && cause != 5'h0b) ? tval : '0;
      end else if (kind == 2) begin
        rpc = m_mepc; m_mie = m_mpie; m_mpie = 1'b1;
      end else begin
        if (mst_we) {m_mpie, m_mie} = wmst;
        if (mepc_we) m_mepc = wmepc;
      end
      drive_instr(pc, it, lt, et, ip, en, mtvec, tval);
      instr_valid_i = valid;
      csr_mstatus_we_i = mst_we; csr_mstatus_i = wmst;
      csr_mepc_we_i = mepc_we; csr_mepc_i = wmepc;
      step();
      idle_inputs();
      chk("rnd_flush", flush_o, (kind != 0));
      chk("rnd_valid", rif.redirect_valid, (kind != 0));
      chk("rnd_state", tcu_state_o, m_state);
      chk("rnd_mepc", mepc_o, m_mepc);
      chk("rnd_mcause", mcause_o, m_mcause);
      chk("rnd_mstatus", mstatus_o, {m_mpie, m_mie});
      chk("rnd_mtval", mtval_o, m_mtval);
      if (kind != 0) begin
        exp_q.push_back(rpc);
        finish_redirect($urandom_range(0, 3), m_state);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
